// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: shared FSM state, op encoding and index-width helper for sr_bank_ctrl
package sr_bank_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr+1 and wraps
//   req     requests, one bit per requester
//   ptr     index of the last winner
//   win     one-hot winner (zero when no request)
//   win_idx binary index of the winner
module rr_arbiter
  import sr_bank_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx
);
  logic          found;
  logic [PW-1:0] c;
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    c       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      c = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[c]) begin
        found   = 1'b1;
        win_idx = c;
      end
    end
  end
  assign win = found ? NREQ'(1) << win_idx : '0;
endmodule

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin sequencer driving legal s/r/en patterns into an SR cell bank
//   req/op_set/op_idx  per-requester level request, op (1 set, 0 clear), cell index
//   gnt                one-hot registered grant pulse
//   done/busy          commit pulse / high in APPLY and HOLD
//   s/r/en             bank drive lines, at most one en bit high
//   q                  registered shadow of the bank state
//   q_in/err           bank readback and sticky mismatch flag (SR_ARB_READBACK_EN)
module sr_bank_ctrl
  import sr_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = idx_w(NBITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op_set,
  input  logic [NREQ*IDXW-1:0] op_idx,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic                 busy,
  output logic [NBITS-1:0]     s,
  output logic [NBITS-1:0]     r,
  output logic [NBITS-1:0]     en,
  output logic [NBITS-1:0]     q,
  input  logic [NBITS-1:0]     q_in,
  output logic                 err
);
  localparam int PW = idx_w(NREQ);
  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic [NBITS-1:0] s_q, s_d, r_q, r_d, en_q, en_d, q_q, q_d;
  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic [IDXW-1:0] sel_idx;
  logic            sel_set;
  logic [NBITS-1:0] dec;
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req(req), .ptr(ptr_q), .win(win), .win_idx(win_idx)
  );
  assign sel_idx = op_idx[int'(win_idx)*IDXW +: IDXW];
  assign sel_set = op_set[win_idx];
  // out-of-range indices decode to no enable, so they sequence without touching the bank
  assign dec = (int'(sel_idx) < NBITS) ? NBITS'(1) << sel_idx : '0;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    s_d     = '0;
    r_d     = '0;
    en_d    = '0;
    q_d     = q_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (|req) begin
        state_d = ST_APPLY;
        ptr_d   = win_idx;
        gnt_d   = win;
        busy_d  = 1'b1;
        en_d    = dec;
        s_d     = (sel_set == OP_SET) ? dec : '0;
        r_d     = (sel_set == OP_CLR) ? dec : '0;
      end
      ST_APPLY: begin
        state_d = ST_HOLD;
        done_d  = 1'b1;
        // s_q/r_q still hold the one-hot pattern of the op being applied
        q_d     = (q_q | s_q) & ~r_q;
`ifdef SR_ARB_READBACK_EN
        err_d   = err_q | (|(s_q & ~q_in)) | (|(r_q & q_in));
`endif
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
`ifndef SR_ARB_READBACK_EN
    err_d = 1'b0;
`endif
  end
`ifndef SR_ARB_READBACK_EN
  logic unused_q_in;
  assign unused_q_in = ^q_in;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      en_q    <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      s_q     <= s_d;
      r_q     <= r_d;
      en_q    <= en_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end
  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign s    = s_q;
  assign r    = r_q;
  assign en   = en_q;
  assign q    = q_q;
  assign err  = err_q;
endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: scoreboard bench for sr_bank_ctrl (NREQ=4, NBITS=8, 4-bit index)
module tb_sr_bank_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0, op_set = '0, gnt;
  logic [15:0] op_idx = '0;
  logic        done, busy, err;
  logic [7:0]  s, r, en, q, q_in = '0;
  int checks = 0, errors = 0;
`ifdef SR_ARB_READBACK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] g;
    logic [7:0] e, s, r, q;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  bit   pend = 0;
  logic [7:0] model_q = '0;

  sr_bank_ctrl #(.NREQ(4), .NBITS(8), .IDXW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .op_set(op_set), .op_idx(op_idx),
    .gnt(gnt), .done(done), .busy(busy), .s(s), .r(r), .en(en),
    .q(q), .q_in(q_in), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) pend = 0;
    else begin
      checks++;
      if (done !== pend) begin
        errors++;
        $display("FAIL done_pulse: got %b want %b at %0t", done, pend, $time);
      end
      if (pend) begin
        checks++;
        if ({q, en, s, r} !== {cur.q, 24'h0}) begin
          errors++;
          $display("FAIL hold: got q=%h en=%h s=%h r=%h want q=%h en/s/r=0", q, en, s, r, cur.q);
        end
      end
      pend = 0;
      if (gnt !== 4'h0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_gnt: got gnt=%b want no grant", gnt);
        end else begin
          cur = sb.pop_front();
          pend = 1;
          if ({gnt, en, s, r} !== {cur.g, cur.e, cur.s, cur.r}) begin
            errors++;
            $display("FAIL apply: got gnt=%b en=%h s=%h r=%h want gnt=%b en=%h s=%h r=%h",
                     gnt, en, s, r, cur.g, cur.e, cur.s, cur.r);
          end
        end
      end
    end
  end

  task automatic set_op(input int k, input logic set, input logic [3:0] idx);
    logic [7:0] e;
    e = (idx < 4'd8) ? 8'(1) << idx : 8'h00;
    model_q = set ? (model_q | e) : (model_q & ~e);
    sb.push_back('{g: 4'(1) << k, e: e, s: set ? e : 8'h00, r: set ? 8'h00 : e, q: model_q});
    op_set[k] = set;
    op_idx[k*4 +: 4] = idx;
    req[k] = 1'b1;
    q_in = model_q;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      req = req & ~gnt;
      if (req == 4'h0 && !busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    req = '0;
    model_q = '0;
    q_in = '0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, done, busy, err} !== 7'h0) begin
      errors++;
      $display("FAIL reset_ctl: got gnt=%b done=%b busy=%b err=%b want 0", gnt, done, busy, err);
    end
    checks++;
    if ({s, r, en, q} !== 32'h0) begin
      errors++;
      $display("FAIL reset_bank: got s=%h r=%h en=%h q=%h want 0", s, r, en, q);
    end
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    set_op(0, 1'b1, 4'd3);
    drain(20, ok);
    checks++;
    if (!ok || q !== 8'h08) begin
      errors++;
      $display("FAIL single: got ok=%b q=%h want ok=1 q=08", ok, q);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL single_err: got %b want 0", err);
    end
  endtask

  task automatic test_contention();
    int last = -1, n = 0;
    pulse_rst();
    for (int k = 0; k < 4; k++) set_op(k, 1'b1, 4'(k + 4));
    for (int c = 0; c < 60 && (req != 4'h0 || busy); c++) begin
      @(negedge clk);
      if (gnt != 4'h0) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 3) begin
            errors++;
            $display("FAIL contention_spacing: got %0d cycles want 3", c - last);
          end
        end
        last = c;
        n++;
      end
      req = req & ~gnt;
    end
    checks++;
    if (n != 4 || q !== 8'hF0 || sb.size() != 0) begin
      errors++;
      $display("FAIL contention: got grants=%0d q=%h left=%0d want 4 F0 0", n, q, sb.size());
    end
  endtask

  task automatic test_rr_fairness();
    bit ok;
    set_op(1, 1'b1, 4'd0);
    drain(20, ok);
    set_op(0, 1'b0, 4'd4);
    set_op(1, 1'b0, 4'd5);
    drain(30, ok);
    checks++;
    if (!ok || q !== 8'hC1 || sb.size() != 0) begin
      errors++;
      $display("FAIL rr_fairness: got ok=%b q=%h left=%0d want 1 C1 0", ok, q, sb.size());
    end
  endtask

  task automatic test_clear_redundant();
    bit ok;
    pulse_rst();
    set_op(2, 1'b1, 4'd5);
    drain(20, ok);
    checks++;
    if (!ok || q !== 8'h20) begin
      errors++;
      $display("FAIL set5: got ok=%b q=%h want 1 20", ok, q);
    end
    set_op(2, 1'b0, 4'd5);
    drain(20, ok);
    checks++;
    if (!ok || q !== 8'h00) begin
      errors++;
      $display("FAIL clear5: got ok=%b q=%h want 1 00", ok, q);
    end
    set_op(2, 1'b0, 4'd5);
    drain(20, ok);
    checks++;
    if (!ok || q !== 8'h00) begin
      errors++;
      $display("FAIL reclear5: got ok=%b q=%h want 1 00", ok, q);
    end
    set_op(3, 1'b1, 4'd9);
    drain(20, ok);
    checks++;
    if (!ok || q !== 8'h00 || sb.size() != 0) begin
      errors++;
      $display("FAIL idx9: got ok=%b q=%h left=%0d want 1 00 0", ok, q, sb.size());
    end
  endtask

  task automatic test_reset_apply();
    bit ok, seen = 0;
    set_op(1, 1'b1, 4'd1);
    drain(20, ok);
    set_op(3, 1'b1, 4'd6);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt != 4'h0) begin
        seen = 1;
        break;
      end
    end
    req = req & ~gnt;
    checks++;
    if (!seen || en !== 8'h40) begin
      errors++;
      $display("FAIL apply_seen: got seen=%b en=%h want 1 40", seen, en);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({en, s, r, q} !== 32'h0 || {gnt, done, busy} !== 6'h0) begin
      errors++;
      $display("FAIL reset_apply: got en=%h s=%h r=%h q=%h gnt=%b done=%b busy=%b want 0",
               en, s, r, q, gnt, done, busy);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    model_q = '0;
    q_in = '0;
    set_op(0, 1'b1, 4'd7);
    drain(20, ok);
    checks++;
    if (!ok || q !== 8'h80 || sb.size() != 0) begin
      errors++;
      $display("FAIL after_reset: got ok=%b q=%h left=%0d want 1 80 0", ok, q, sb.size());
    end
  endtask

  task automatic test_readback();
    bit ok;
    set_op(2, 1'b1, 4'd2);
    q_in[2] = 1'b0;
    drain(20, ok);
    checks++;
    if (!ok || err !== EXP_ERR) begin
      errors++;
      $display("FAIL readback_bad: got ok=%b err=%b want 1 %b", ok, err, EXP_ERR);
    end
    set_op(0, 1'b1, 4'd4);
    drain(20, ok);
    checks++;
    if (!ok || err !== EXP_ERR || q !== 8'h94) begin
      errors++;
      $display("FAIL readback_sticky: got ok=%b err=%b q=%h want 1 %b 94", ok, err, q, EXP_ERR);
    end
    pulse_rst();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL readback_clear: got err=%b want 0", err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rr_fairness();
    test_clear_redundant();
    test_reset_apply();
    test_readback();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_bank_ctrl.md
# sr_bank_ctrl

Sequencing controller and round-robin arbiter for a bank of NBITS enable-gated SR cells. Up to NREQ requesters issue single-bit set/clear operations. The block grants one at a time and drives the cell's s/r/en inputs with only legal patterns: never s=r=0 or s=r=1 while enabled. It keeps a shadow copy of the bank's stored state, because the cells present valid output only while enabled. It sits between control logic and the SR cell bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of SR cells in the bank (2..32)
- IDXW, $clog2(NBITS), derived width of a cell index
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset; one clock only
- req  in  NREQ  per-requester request, level, held until granted
- op_set  in  NREQ  per-requester op: 1 = set cell, 0 = clear cell
- op_idx  in  NREQ*IDXW  per-requester cell index, requester k at [k*IDXW +: IDXW]
- gnt  out  NREQ  one-hot grant, one-cycle pulse, registered
- done  out  1  one-cycle pulse, operation committed to shadow
- busy  out  1  high in APPLY and HOLD
- s  out  NBITS  set lines to the bank
- r  out  NBITS  reset lines to the bank
- en  out  NBITS  enable lines to the bank, at most one bit high
- q  out  NBITS  shadow of the bank state, registered
- q_in  in  NBITS  bank q outputs; used only with the readback feature
- err  out  1  sticky readback mismatch flag

## Operation
- FSM has three states, encoded IDLE / APPLY / HOLD.
- IDLE
  - If any req is high at the clock edge, the round-robin winner w is captured: op_set[w], op_idx[w].
  - gnt[w] is set to 1 and the FSM moves to APPLY.
  - If no req is high, the FSM stays in IDLE.
- APPLY (exactly 1 cycle)
  - en[idx]=1.
  - Set op: s[idx]=1, r[idx]=0. Clear op: s[idx]=0, r[idx]=1.
  - All other s/r/en bits are 0.
  - Next state is HOLD.
- HOLD (exactly 1 cycle)
  - en, s and r are all 0.
  - q[idx] was updated at the APPLY->HOLD edge.
  - done=1.
  - Next state is IDLE.
- Round robin
  - The pointer holds the last winner; the search starts at last+1 and wraps modulo NREQ.
  - The pointer updates only when a grant is issued.
- Index range: an op_idx >= NBITS is still granted and completed, with done pulsed, but no en bit is driven and q is unchanged.
- Requester rule: the requester drops req, or presents its next op, in the cycle gnt is high. A req still high in HOLD counts as a new request at the next IDLE.
- Repeated ops: setting an already-set cell or clearing an already-clear cell is legal. It is sequenced normally and q is unchanged.

## Timing
- Reset values: gnt=0, done=0, busy=0, s=r=en=0, q=0, err=0, FSM=IDLE, RR pointer=NREQ-1, so requester 0 wins first.
- Latency
  - req sampled at edge E0 -> gnt and en high in cycle E0..E1.
  - q updated and done high in cycle E1..E2.
  - Back in IDLE from E2.
- Throughput: one op per 3 cycles. Requests arriving while busy wait; they are not dropped.
- Simultaneous requests: the RR order decides the winner; losers keep req high and are served in later turns.
- Reset mid-operation: all outputs return to their reset values immediately, asynchronously. The in-flight op is lost and no done is issued.
- All outputs are registered; nothing combinational from req to any output.

## Configuration
- SR_ARB_READBACK_EN defined
  - In APPLY, q_in[idx] is sampled at the APPLY->HOLD edge and compared with the expected value (1 for set, 0 for clear).
  - On a mismatch, err is set and stays set until rst.
  - Out-of-range indices are not checked.
- SR_ARB_READBACK_EN undefined
  - err is tied to 0 and q_in is ignored.
  - Ports are unchanged.

## Structure
- Package sr_bank_pkg holds:
  - the state enum (ST_IDLE, ST_APPLY, ST_HOLD);
  - the op encoding constants OP_SET=1'b1, OP_CLR=1'b0;
  - an index-width helper function.
- One sub-module, rr_arbiter: parameter NREQ; inputs req and pointer; outputs a one-hot winner and its binary index. It is purely combinational and instantiated once.

## Test plan
- Reset, then one op: req0 requests set of idx 3 -> gnt[0] high 1 cycle later; en=8'h08 and s[3]=1 for 1 cycle; then done high and q=8'h08.
- Contention: req=4'b1111 held, each requester targeting a distinct cell -> grants issued in order 0,1,2,3, one every 3 cycles.
- RR fairness: after requester 1 is served, req=4'b0011 -> requester 0 is granted next, then requester 1.
- Clear and redundant ops: set idx 5, then clear idx 5 -> q=0. A second clear of idx 5 -> done pulses and q stays 0. An op with idx 9 when NBITS=8 -> done pulses, en stays 0, q unchanged.
- Reset in APPLY: rst asserted while en is high -> en, s, r and gnt go to 0 at once; q=0; no done pulse; the next request after reset is served normally.
- Readback (macro defined): set idx 2 with q_in[2] forced to 0 -> err=1 and stays set through later good ops until rst. With the macro undefined, err stays 0.
